fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Sequences the synchronous instruction memory for the 16-bit CPU. Owns the fetch PC, drives the memory address every cycle, tracks the one-cycle read latency, holds the presented instruction stable under decode stall, and redirects on taken branches/jumps. Sits between the instruction memory and the decode stage.

## Interface

Parameters:
- ADDR_W, 16: fetch address width.
- RESET_PC, 16'h0000: first address fetched after reset.
- HALT_OPCODE, 4'hF: value of instr[15:12] treated as halt. Used only when FETCH_HALT_EN is defined.

Ports (one clock; reset is asynchronous and active-high):
- clk, in, 1: clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- imem_addr, out, ADDR_W: address to instruction memory. Memory returns data one cycle later.
- imem_rdata, in, 16: memory read data for the address presented in the previous cycle.
- stall, in, 1: decode cannot accept the presented instruction; hold it.
- redirect, in, 1: taken branch/jump; discard stream and fetch from redirect_pc.
- redirect_pc, in, ADDR_W: redirect target.
- instr, out, 16: presented instruction. Passthrough of imem_rdata, qualified by instr_valid.
- instr_pc, out, ADDR_W: address of instr.
- instr_valid, out, 1: instr/instr_pc are a real fetched instruction.
- halted, out, 1: fetch stopped on halt. Constant 0 without FETCH_HALT_EN.

## Operation

- Registers:
  - fetch_pc: next address to issue.
  - d_valid / d_pc: issued-last-cycle tracking.
  - State: FILL (d_valid=0), RUN (d_valid=1), HALT.
- Issue address, in priority order:
  - redirect: imem_addr = redirect_pc.
  - RUN && stall: imem_addr = d_pc, so the same word is re-read.
  - Otherwise: imem_addr = fetch_pc.
- Redirect has highest priority in every state, including HALT and stall:
  - Next cycle: d_pc = redirect_pc, d_valid = 1, fetch_pc = redirect_pc+1.
  - State goes to RUN. halted clears.
- FILL (no stall effect): issue fetch_pc. Next cycle d_pc = fetch_pc, d_valid = 1, fetch_pc += 1. Go to RUN.
- RUN, no stall: instruction consumed. Issue fetch_pc, then d_pc = fetch_pc, fetch_pc += 1.
- RUN, stall: d_pc, d_valid and fetch_pc hold. instr stays stable because the same address is re-read.
- HALT: imem_addr = d_pc, d_valid = 0, halted = 1. Leaves only via redirect or reset.
- Arithmetic: fetch_pc+1 is modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000 with no flag.
- Reset mid-operation: state immediately becomes FILL. In-flight data is discarded.

## Timing

- Reset values:
  - imem_addr = RESET_PC, instr_pc = RESET_PC.
  - instr_valid = 0, halted = 0.
  - fetch_pc = RESET_PC, state FILL.
  - instr is undefined (passthrough).
- After reset deasserts, the first edge issues RESET_PC. instr_valid = 1 with instr = mem[RESET_PC] one cycle later.
- Steady state: one instruction per cycle. Fetch latency is 1 cycle from issue to presentation.
- Redirect asserted in cycle N:
  - The instruction presented in N is dropped by the consumer.
  - Cycle N+1 presents mem[redirect_pc], valid.
  - No bubble.
- Stall in cycle N with instr_valid: outputs in N+1 equal those in N.
- Stall and redirect in the same cycle: redirect wins.
- No combinational path from stall/redirect to instr_valid. instr_valid is registered (d_valid).

## Configuration

- FETCH_HALT_EN defined:
  - In RUN, no stall, no redirect, instr[15:12] == HALT_OPCODE: the halt is consumed that cycle, and the next state is HALT.
  - Redirect in the detection cycle wins; no halt.
  - Halt presented while stall = 1 is not yet consumed; no transition.
- FETCH_HALT_EN undefined: no halt decode, no HALT state, halted tied 0. The halt opcode streams like any instruction.

## Structure

- Shared package/defines:
  - Address width.
  - RESET_PC default.
  - Opcode field position [15:12].
  - HALT opcode constant.
  - State encoding for FILL/RUN/HALT.
- Single module; no sub-module needed.
- Halt compare is an inline `ifdef region.

## Test plan

- Reset then release, mem[0..3] = 16'h1111..16'h4444:
  - First valid cycle is instr = 16'h1111, instr_pc = 0.
  - Then 16'h2222, 16'h3333 on consecutive cycles.
- Stall for 3 cycles while instr_pc = 2:
  - instr = 16'h3333, instr_pc = 2 held for all 3 cycles.
  - imem_addr = 2 during stall.
  - Next cycle instr_pc = 3.
- Redirect to 16'h0040 with stall = 1 in the same cycle:
  - Next cycle instr_pc = 16'h0040, instr = mem[0x40], valid.
  - Then 16'h0041.
- Redirect to 16'hFFFF: instr_pc sequence is FFFF, 0000, 0001 (wrap).
- FETCH_HALT_EN, mem[5] = 16'hF000:
  - After instr_pc = 5 is consumed, instr_valid = 0 and halted = 1, held 10 cycles.
  - Redirect to 0 restarts with instr_pc = 0, halted = 0.
- Assert reset asynchronously mid-stream (between edges):
  - instr_valid drops immediately and imem_addr = RESET_PC.
  - After release, the stream restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared widths, opcode field and state encoding for fetch_sequencer
package fetch_sequencer_pkg;

  localparam int          FS_ADDR_W      = 16;
  localparam logic [15:0] FS_RESET_PC    = 16'h0000;
  localparam int          FS_OPC_HI      = 15;
  localparam int          FS_OPC_LO      = 12;
  localparam logic [3:0]  FS_HALT_OPCODE = 4'hF;

  // FILL: nothing issued last cycle; RUN: d_pc was issued last cycle; HALT: stopped
  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch PC sequencer for a 1-cycle synchronous imem
// Optional halt decode enabled by defining FETCH_HALT_EN.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W      = FS_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(FS_RESET_PC),
  parameter logic [3:0]        HALT_OPCODE = FS_HALT_OPCODE
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              halted
);

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_n;
  logic [ADDR_W-1:0] d_pc, d_pc_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_FILL;
      fetch_pc <= RESET_PC;
      d_pc     <= RESET_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      d_pc     <= d_pc_n;
    end
  end

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    d_pc_n     = d_pc;
    imem_addr  = fetch_pc;
    if (redirect) begin
      imem_addr  = redirect_pc;
      state_n    = ST_RUN;
      d_pc_n     = redirect_pc;
      fetch_pc_n = redirect_pc + ADDR_W'(1);
    end else begin
      case (state)
        ST_FILL: begin
          state_n    = ST_RUN;
          d_pc_n     = fetch_pc;
          fetch_pc_n = fetch_pc + ADDR_W'(1);
        end
        ST_RUN: begin
          // Re-reading d_pc keeps the passthrough instr stable while decode stalls
          if (stall) begin
            imem_addr = d_pc;
          end else begin
`ifdef FETCH_HALT_EN
            if (imem_rdata[FS_OPC_HI:FS_OPC_LO] == HALT_OPCODE) begin
              state_n = ST_HALT;
            end else begin
              d_pc_n     = fetch_pc;
              fetch_pc_n = fetch_pc + ADDR_W'(1);
            end
`else
            d_pc_n     = fetch_pc;
            fetch_pc_n = fetch_pc + ADDR_W'(1);
`endif
          end
        end
        ST_HALT: begin
          imem_addr = d_pc;
        end
        default: begin
          state_n = ST_FILL;
        end
      endcase
    end
  end

  assign instr       = imem_rdata;
  assign instr_pc    = d_pc;
  assign instr_valid = (state == ST_RUN);

`ifdef FETCH_HALT_EN
  assign halted = (state == ST_HALT);
`else
  logic unused_halt_opcode;
  assign unused_halt_opcode = ^HALT_OPCODE;
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer against a stream-level model
module tb_fetch_sequencer;

  localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        halted;

  logic [15:0] mem [0:65535];

  int errors = 0;
  int checks = 0;

  // Model of what the consumer sees: presented pc, valid, halted
  logic        m_valid;
  logic [15:0] m_pc;
  logic        m_halted;

  fetch_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_pc     = RESET_PC;
    m_halted = 1'b0;
  endtask

  // Drive one cycle's inputs, compare mid-cycle, then advance the model past the edge
  task automatic cycle(input logic s, input logic r, input logic [15:0] rpc);
    logic [15:0] ea, np, word;
    logic        nv, nh;
    stall = s;
    redirect = r;
    redirect_pc = rpc;
    #4;
    if (r)              ea = rpc;
    else if (m_halted)  ea = m_pc;
    else if (!m_valid)  ea = RESET_PC;
    else if (s)         ea = m_pc;
    else                ea = m_pc + 16'd1;
    check("imem_addr", imem_addr, ea);
    check("instr_valid", 16'(instr_valid), 16'(m_valid));
    check("halted", 16'(halted), 16'(m_halted));
    if (m_valid) begin
      word = mem[m_pc];
      check("instr_pc", instr_pc, m_pc);
      check("instr", instr, word);
    end
    word = mem[m_pc];
    nv = m_valid; np = m_pc; nh = m_halted;
    if (r) begin
      nv = 1'b1; np = rpc; nh = 1'b0;
    end else if (m_halted) begin
      nv = 1'b0;
    end else if (!m_valid) begin
      nv = 1'b1; np = RESET_PC;
    end else if (s) begin
      nv = 1'b1;
    end else if (HALT_EN && word[15:12] == 4'hF) begin
      nv = 1'b0; nh = 1'b1;
    end else begin
      np = m_pc + 16'd1;
    end
    @(posedge clk);
    #1;
    m_valid = nv; m_pc = np; m_halted = nh;
  endtask

  initial begin
    logic [15:0] v;
    for (int i = 0; i < 65536; i++) begin
      v = 16'($urandom);
      mem[i] = v & 16'hEFFF;
    end
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    mem[2] = 16'h3333;
    mem[3] = 16'h4444;
    mem[5] = 16'hF000;

    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_imem_addr", imem_addr, RESET_PC);
    check("rst_instr_pc", instr_pc, RESET_PC);
    check("rst_instr_valid", 16'(instr_valid), 16'h0);
    check("rst_halted", 16'(halted), 16'h0);
    reset = 1'b0;

    cycle(1'b0, 1'b0, 16'h0);
    check("first_instr", instr, 16'h1111);
    check("first_pc", instr_pc, 16'h0000);
    cycle(1'b0, 1'b0, 16'h0);
    check("second_instr", instr, 16'h2222);
    cycle(1'b0, 1'b0, 16'h0);
    check("third_instr", instr, 16'h3333);

    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 16'h0);
      check("stall_instr", instr, 16'h3333);
      check("stall_pc", instr_pc, 16'h0002);
    end
    cycle(1'b0, 1'b0, 16'h0);
    check("after_stall_pc", instr_pc, 16'h0003);
    cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0);
    check("pc5", instr_pc, 16'h0005);
    cycle(1'b0, 1'b0, 16'h0);
`ifdef FETCH_HALT_EN
    check("halt_valid", 16'(instr_valid), 16'h0);
    check("halt_flag", 16'(halted), 16'h1);
`else
    check("no_halt_pc", instr_pc, 16'h0006);
    check("no_halt_flag", 16'(halted), 16'h0);
`endif
    repeat (10) cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 16'h0000);
    check("restart_pc", instr_pc, 16'h0000);
    check("restart_halted", 16'(halted), 16'h0);
    cycle(1'b0, 1'b0, 16'h0);

    cycle(1'b1, 1'b1, 16'h0040);
    check("redir_pc", instr_pc, 16'h0040);
    check("redir_valid", 16'(instr_valid), 16'h1);
    cycle(1'b0, 1'b0, 16'h0);
    check("redir_next_pc", instr_pc, 16'h0041);

    cycle(1'b0, 1'b1, 16'hFFFF);
    check("wrap_ffff", instr_pc, 16'hFFFF);
    cycle(1'b0, 1'b0, 16'h0);
    check("wrap_0000", instr_pc, 16'h0000);
    cycle(1'b0, 1'b0, 16'h0);
    check("wrap_0001", instr_pc, 16'h0001);

    for (int i = 0; i < 300; i++) begin
      logic        s, r;
      logic [15:0] t;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 9) == 0);
      t = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1))
                                      : 16'($urandom);
      cycle(s, r, t);
    end

    cycle(1'b0, 1'b1, 16'h0100);
    cycle(1'b0, 1'b0, 16'h0);
    stall = 1'b0;
    redirect = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_valid", 16'(instr_valid), 16'h0);
    check("async_addr", imem_addr, RESET_PC);
    check("async_pc", instr_pc, RESET_PC);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    cycle(1'b0, 1'b0, 16'h0);
    check("rerun_pc", instr_pc, RESET_PC);
    check("rerun_instr", instr, 16'h1111);
    repeat (4) cycle(1'b0, 1'b0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
